// File: rtl/scan_pkg.sv
// Shared constants for the 7-segment scan capture: glyph table and digit indexing.
// Segment patterns are active-high, bit0=a .. bit6=g.
package scan_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam int SEG_DP_BIT = 7;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/seg7_decode.sv
// Combinational reverse lookup of a 7-segment glyph to {invalid, nibble}.
// Unknown patterns (blank included) decode as nibble 0 with invalid set.
module seg7_decode
    import scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic [4:0] code
);

    always_comb begin
        code = 5'h10;
        case (seg)
            SEG_0:   code = 5'h00;
            SEG_1:   code = 5'h01;
            SEG_2:   code = 5'h02;
            SEG_3:   code = 5'h03;
            SEG_4:   code = 5'h04;
            SEG_5:   code = 5'h05;
            SEG_6:   code = 5'h06;
            SEG_7:   code = 5'h07;
            SEG_8:   code = 5'h08;
            SEG_9:   code = 5'h09;
            SEG_A:   code = 5'h0A;
            SEG_B:   code = 5'h0B;
            SEG_C:   code = 5'h0C;
            SEG_D:   code = 5'h0D;
            SEG_E:   code = 5'h0E;
            SEG_F:   code = 5'h0F;
            default: code = 5'h10;
        endcase
    end

endmodule

// File: rtl/scan_display_capture.sv
// Monitors a multiplexed 4-digit 7-segment scan bus and rebuilds whole frames
// as hex nibbles, handed out over valid/ready with overrun and stale flags.
//
// state  | meaning
// IDLE   | blanking interval, no digit enabled
// SETTLE | sample seen, counting identical samples before capture
// HOLD   | digit captured, waiting for the bus to move on
module scan_display_capture
    import scan_pkg::*;
#(
    parameter int SCAN_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW  = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int SETTLE          = 4,
    parameter int TIMEOUT         = 65535
) (
    input  logic        FPGA_clk,
    input  logic        clr,
    input  logic [3:0]  ScanEn,
    input  logic [7:0]  Dout,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic [3:0]  glyph_err,
    output logic        scan_err,
    output logic        overrun,
    output logic        stale
);

    localparam logic [3:0] SCAN_IDLE = (SCAN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
    localparam logic [7:0] SEG_IDLE  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETTLE_ST, HOLD} state_t;

    logic [3:0]  scan_sync [SYNC_STAGES];
    logic [7:0]  seg_sync  [SYNC_STAGES];
    logic [3:0]  scan;
    logic [7:0]  seg;
    logic [11:0] sample, prev_sample;
    state_t      state;
    logic [7:0]  cnt;
    logic [TW-1:0] to_cnt;
    logic [15:0] dig_r;
    logic [3:0]  dp_r, err_r, seen;
    logic [4:0]  dec_code;
    logic        changed, fresh, capture, one_hot, frame_done, to_hit;
    digit_idx_t  idx;

    // Synchroniser flops reset to the bus idle level so nothing looks enabled.
    always_ff @(posedge FPGA_clk) begin
        if (clr) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                scan_sync[i] <= SCAN_IDLE;
                seg_sync[i]  <= SEG_IDLE;
            end
        end else begin
            scan_sync[0] <= ScanEn;
            seg_sync[0]  <= Dout;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scan_sync[i] <= scan_sync[i-1];
                seg_sync[i]  <= seg_sync[i-1];
            end
        end
    end

    assign scan    = scan_sync[SYNC_STAGES-1] ^ SCAN_IDLE;
    assign seg     = seg_sync[SYNC_STAGES-1] ^ SEG_IDLE;
    assign sample  = {scan, seg};
    assign changed = (sample != prev_sample);

    seg7_decode u_dec (
        .seg  (seg[SEG_DP_BIT-1:0]),
        .code (dec_code)
    );

    always_comb begin
        one_hot = 1'b1;
        idx     = '0;
        case (scan)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    // fresh: a new nonzero sample opens a settle window with cnt=1.
    always_comb begin
        fresh   = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE:      fresh = (scan != 4'h0);
            SETTLE_ST: begin
                if (changed) fresh = (scan != 4'h0);
                else         capture = (cnt == 8'(SETTLE - 1));
            end
            HOLD:      fresh = changed && (scan != 4'h0);
            default:   fresh = 1'b0;
        endcase
        if (fresh && SETTLE == 1) capture = 1'b1;
    end

    assign frame_done = (seen == 4'hF);
    assign to_hit     = !capture && (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge FPGA_clk) begin
        if (clr) begin
            prev_sample <= '0;
            state       <= IDLE;
            cnt         <= '0;
            to_cnt      <= '0;
            dig_r       <= '0;
            dp_r        <= '0;
            err_r       <= '0;
            seen        <= '0;
            frame_valid <= 1'b0;
            digits      <= '0;
            dps         <= '0;
            glyph_err   <= '0;
            scan_err    <= 1'b0;
            overrun     <= 1'b0;
            stale       <= 1'b0;
        end else begin
            prev_sample <= sample;

            if (capture) begin
                state <= HOLD;
            end else if (fresh) begin
                state <= SETTLE_ST;
                cnt   <= 8'd1;
            end else if (state == SETTLE_ST) begin
                if (changed) state <= IDLE;
                else         cnt   <= cnt + 8'd1;
            end else if (state == HOLD && changed) begin
                state <= IDLE;
            end

            scan_err <= capture && !one_hot;

            if (capture)                    to_cnt <= '0;
            else if (to_cnt != TW'(TIMEOUT)) to_cnt <= to_cnt + 1'b1;

            if (capture)     stale <= 1'b0;
            else if (to_hit) stale <= 1'b1;

            // Clear first so a capture in the same cycle still lands in seen.
            if (frame_done || to_hit) seen <= '0;
            if (capture && one_hot) begin
                dig_r[{idx, 2'b00} +: 4] <= dec_code[3:0];
                dp_r[idx]                <= seg[SEG_DP_BIT];
                err_r[idx]               <= dec_code[4];
                seen[idx]                <= 1'b1;
            end

            if (frame_done) begin
                digits      <= dig_r;
                dps         <= dp_r;
                glyph_err   <= err_r;
                frame_valid <= 1'b1;
                if (frame_valid && !frame_ready) overrun <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scan_display_capture.sv
// Directed bench for scan_display_capture: drives active-low scan frames and
// compares the rebuilt frame against hand-computed values.
module tb_scan_display_capture;

    logic        FPGA_clk = 1'b0;
    logic        clr = 1'b1;
    logic [3:0]  ScanEn = 4'hF;
    logic [7:0]  Dout = 8'hFF;
    logic        frame_ready = 1'b0;
    logic        frame_valid;
    logic [15:0] digits;
    logic [3:0]  dps, glyph_err;
    logic        scan_err, overrun, stale;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int serr_cnt = 0;
    int serr_base;
    int c0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    scan_display_capture #(.TIMEOUT(100)) dut (
        .FPGA_clk    (FPGA_clk),
        .clr         (clr),
        .ScanEn      (ScanEn),
        .Dout        (Dout),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .digits      (digits),
        .dps         (dps),
        .glyph_err   (glyph_err),
        .scan_err    (scan_err),
        .overrun     (overrun),
        .stale       (stale)
    );

    always #5 FPGA_clk = ~FPGA_clk;
    always @(posedge FPGA_clk) cyc <= cyc + 1;
    always @(negedge FPGA_clk) if (scan_err) serr_cnt <= serr_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic show(input int k, input logic [6:0] pat, input logic dp, input int n);
        ScanEn = ~(4'(1) << k);
        Dout   = ~{dp, pat};
        repeat (n) @(posedge FPGA_clk);
        #1;
    endtask

    task automatic blank(input int n);
        ScanEn = 4'hF;
        Dout   = 8'hFF;
        repeat (n) @(posedge FPGA_clk);
        #1;
    endtask

    task automatic digit(input int k, input logic [3:0] nib, input logic dp);
        show(k, glyph[nib], dp, 8);
        blank(2);
    endtask

    task automatic frame(input logic [15:0] d, input logic [3:0] dp);
        for (int k = 0; k < 4; k++) digit(k, d[4*k +: 4], dp[k]);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        ScanEn = 4'hF;
        Dout = 8'hFF;
        repeat (2) @(posedge FPGA_clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic accept();
        frame_ready = 1'b1;
        @(posedge FPGA_clk);
        #1;
        frame_ready = 1'b0;
        @(negedge FPGA_clk);
        chk("accept_valid", frame_valid, 0);
        @(posedge FPGA_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d limit=20000", cyc);
        $fatal(1);
    end

    initial begin
        @(posedge FPGA_clk);
        #1;
        do_reset();
        chk("reset_all", {frame_valid, digits, dps, glyph_err, scan_err, overrun, stale}, 0);

        // clean frame "1234", dp on digit 2
        frame(16'h4321, 4'b0100);
        chk("f1_valid", frame_valid, 1);
        chk("f1_digits", digits, 16'h4321);
        chk("f1_dps", dps, 4'b0100);
        chk("f1_gerr", glyph_err, 0);
        chk("f1_overrun", overrun, 0);

        // second frame while held
        frame(16'h8765, 4'b0000);
        chk("bp_valid", frame_valid, 1);
        chk("bp_digits", digits, 16'h8765);
        chk("bp_overrun", overrun, 1);
        accept();
        chk("bp_hold_digits", digits, 16'h8765);

        // glitch on digit 3: 3 cycles of "1" then a stable "3"
        do_reset();
        digit(0, 4'h0, 1'b0);
        digit(1, 4'h1, 1'b0);
        digit(2, 4'h2, 1'b0);
        show(3, 7'h06, 1'b0, 3);
        show(3, 7'h4F, 1'b0, 8);
        blank(2);
        chk("gl_valid", frame_valid, 1);
        chk("gl_digits", digits, 16'h3210);
        chk("gl_d3", digits[15:12], 4'h3);
        accept();

        // invalid glyph on digit 1, multi-hot scan in between
        serr_base = serr_cnt;
        digit(0, 4'h0, 1'b0);
        ScanEn = ~4'b0011;
        Dout   = ~{1'b0, 7'h3F};
        repeat (6) @(posedge FPGA_clk);
        #1;
        blank(2);
        digit(2, 4'h2, 1'b0);
        digit(3, 4'h3, 1'b0);
        chk("mh_seen_untouched", frame_valid, 0);
        chk("mh_scan_err_pulses", serr_cnt - serr_base, 1);
        show(1, 7'h49, 1'b0, 8);
        blank(2);
        chk("ig_valid", frame_valid, 1);
        chk("ig_digits", digits, 16'h3200);
        chk("ig_gerr", glyph_err, 4'b0010);

        // timeout after two digits
        do_reset();
        digit(0, 4'h9, 1'b0);
        c0 = cyc;
        digit(1, 4'hA, 1'b0);
        while (cyc < c0 + 105) begin
            @(posedge FPGA_clk);
            #1;
        end
        @(negedge FPGA_clk);
        chk("to_before", stale, 0);
        @(negedge FPGA_clk);
        chk("to_at_100", stale, 1);
        @(posedge FPGA_clk);
        #1;
        digit(2, 4'hB, 1'b0);
        digit(3, 4'hC, 1'b0);
        chk("to_seen_cleared", frame_valid, 0);
        chk("to_stale_cleared", stale, 0);
        digit(0, 4'h9, 1'b0);
        digit(1, 4'hA, 1'b0);
        chk("to_valid", frame_valid, 1);
        chk("to_digits", digits, 16'hCBA9);
        chk("to_stale", stale, 0);

        // clr mid-frame discards the partial frame
        digit(0, 4'h1, 1'b0);
        digit(1, 4'h2, 1'b0);
        do_reset();
        chk("clr_outputs", {frame_valid, digits, dps, glyph_err, scan_err, overrun, stale}, 0);
        digit(1, 4'hD, 1'b0);
        digit(2, 4'hE, 1'b0);
        digit(3, 4'hF, 1'b0);
        chk("clr_partial", frame_valid, 0);
        digit(0, 4'h8, 1'b1);
        chk("clr_valid", frame_valid, 1);
        chk("clr_digits", digits, 16'hFED8);
        chk("clr_dps", dps, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_display_capture.md
Name: scan_display_capture

Overview:
- Receive side of the multiplexed 7-segment scan bus that TestBoard drives on ScanEn/Dout.
- Samples the four-digit scan and decodes each segment pattern back to a hex nibble and a decimal-point bit.
- Assembles one complete frame of four digits and hands it out over a valid/ready handshake.
- Used as a bench-side and on-board monitor, so display contents can be checked numerically instead of by eye.

Parameters:
- SCAN_ACTIVE_LOW, 1: ScanEn polarity; inputs are normalised to active-high internally.
- SEG_ACTIVE_LOW, 1: Dout polarity; inputs are normalised to active-high internally.
- SYNC_STAGES, 2: synchroniser flops on ScanEn and Dout; minimum 1.
- SETTLE, 4: consecutive identical samples required before a digit is captured; range 1..255.
- TIMEOUT, 65535: cycles without a capture before the stale condition is declared.

Ports:
- FPGA_clk  in  1  system clock
- clr  in  1  reset; synchronous, active-high
- ScanEn  in  4  digit enables, one-hot when valid
- Dout  in  8  segments; bit0=a … bit6=g, bit7=dp
- frame_valid  out  1  a complete frame is held on the outputs
- frame_ready  in  1  consumer accepts the frame
- digits  out  16  digit k is digits[4k+3:4k]
- dps  out  4  decimal point of digit k
- glyph_err  out  4  digit k had an undecodable pattern
- scan_err  out  1  one-cycle pulse: non-one-hot ScanEn was stable for SETTLE cycles
- overrun  out  1  sticky; a held frame was overwritten
- stale  out  1  no capture within TIMEOUT cycles

Behaviour:
- Reset (clr=1 at a clock edge):
  - All outputs go to 0, the seen mask goes to 0, the FSM goes to IDLE, and the settle and timeout counters go to 0.
  - clr has priority over every other event, including a mid-frame reset: a partial frame is discarded.
- Input path:
  - Both buses pass through SYNC_STAGES flops, then polarity normalisation.
  - Sample s = {scan, seg} after synchronisation.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: scan==0 (blanking interval).
    - scan!=0 → SETTLE, cnt=1.
  - SETTLE: the sample is compared with the previous sample every cycle.
    - Sample changed → cnt=1, or back to IDLE if scan==0.
    - Sample equal and cnt==SETTLE-1: capture occurs this cycle, then go to HOLD.
  - HOLD: wait for the sample to change, then go to IDLE (scan==0) or SETTLE (cnt=1).
  - SETTLE=1 means capture on the first cycle a sample is seen.
- Capture:
  - scan one-hot at k:
    - digit reg k ← decoded nibble, dp reg k ← seg[7], err reg k ← invalid.
    - seen[k] ← 1.
  - scan not one-hot: pulse scan_err, do not touch the seen mask.
  - Recapturing a digit already present in seen overwrites its registers; seen is unchanged.
- Decode (seg[6:0], active-high):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - Any other pattern, including blank 00: nibble=0, invalid=1.
- Frame completion:
  - Happens in the cycle after the capture that makes seen==4'hF.
  - Copies the internal registers to digits/dps/glyph_err, sets frame_valid=1, clears seen.
- Handshake:
  - frame_valid stays high until a cycle with frame_ready=1; it deasserts on the next edge.
  - Outputs are stable while valid && !ready.
  - Completion while valid && !ready: overwrite the outputs, frame_valid stays 1, overrun ← 1 (sticky until clr).
  - Completion in the same cycle as an accept: load the new frame, frame_valid stays 1, no overrun.
- Timeout:
  - Counter increments every cycle and resets to 0 on each capture.
  - Reaching TIMEOUT: stale ← 1, seen ← 0, counter saturates.
  - The next capture clears stale.
- Latency: input change → capture is SYNC_STAGES+SETTLE cycles; last capture → frame_valid is 1 cycle.

Decomposition:
- Package scan_pkg holds:
  - the 16 glyph constants SEG_0..SEG_F;
  - the typedef digit_idx_t (2 bits);
  - the localparam for the segment bit order.
- Sub-module seg7_decode: combinational 7-bit → {invalid, nibble[3:0]} lookup, instantiated once.
- Everything else (synchroniser, FSM, frame registers, handshake, timeout) stays in the top module.

Test Plan:
- Clean frame, defaults:
  - Stimulus: drive active-low patterns for "1234" with dp on digit 2, each digit held 8 cycles with 2 blank cycles between digits.
  - Required: frame_valid rises; digits=16'h4321 (digit0=1); dps=4'b0100; glyph_err=0.
- Backpressure and overrun:
  - Stimulus: hold frame_ready=0 across two frames, "1234" then "5678".
  - Required: outputs show 16'h8765, overrun=1, frame_valid=1.
  - Then frame_ready=1 for 1 cycle: frame_valid=0 on the next edge.
- Glitch rejection:
  - Stimulus: show digit 3 as pattern 06 for 3 cycles, then 4F for 8 cycles.
  - Required: digit3 captured as 3, never as 1.
- Invalid glyph and multi-hot scan:
  - Stimulus: digit 1 shows pattern 49; separately, ScanEn=0011 held stable for 6 cycles.
  - Required: glyph_err[1]=1 with nibble 0; scan_err pulses exactly once; seen mask unaffected by the multi-hot scan.
- Timeout and reset:
  - Stimulus: stop scanning after 2 digits, with TIMEOUT=100.
  - Required: stale=1 at cycle 100 after the last capture; the following full frame completes normally with stale=0.
  - Stimulus: assert clr mid-frame.
  - Required: all outputs 0, and the next frame requires all four digits.
